// File: rtl/pacc_pkg.sv
// pacc_pkg -- shared definitions for the product accumulator.
//   pacc_state_t     : result FSM states (accumulate, send high byte, send low byte)
//   BYTES_PER_RESULT : number of bytes a finished result is serialised into
//   PROD_W           : width of one incoming product
package pacc_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } pacc_state_t;

  localparam int BYTES_PER_RESULT = 2;
  localparam int PROD_W           = 8;

endpackage

// File: rtl/product_accumulator_if.sv
// product_accumulator_if -- handshake bundle between the product source,
// the accumulator and the byte sink.
//   clear                    : synchronous abort/restart
//   in_valid/in_prod/in_ready: product stream into the accumulator
//   out_valid/out_byte/out_last/out_ready: result byte stream out
//   overflow, busy           : status
// slave  = accumulator side, master = environment side.
interface product_accumulator_if;
  import pacc_pkg::*;

  logic              clear;
  logic              in_valid;
  logic [PROD_W-1:0] in_prod;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_byte;
  logic              out_last;
  logic              overflow;
  logic              busy;

  modport slave (
    input  clear, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_byte, out_last, overflow, busy
  );

  modport master (
    output clear, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_byte, out_last, overflow, busy
  );

endinterface

// File: rtl/acc_sat_add.sv
// acc_sat_add -- saturating add of an 8-bit unsigned product into an
// ACC_W-bit accumulator.
//   acc  : current accumulator value
//   prod : product to add (zero-extended)
//   sum  : acc + prod, clamped to all-ones
//   sat  : the true sum did not fit in ACC_W bits
module acc_sat_add
  import pacc_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  // ACC_W is always wider than a product, so one extra carry bit captures
  // every possible overflow of a single add.
  logic [ACC_W:0] full;

  assign full = {1'b0, acc} + (ACC_W+1)'(prod);
  assign sat  = full[ACC_W];
  assign sum  = sat ? '1 : full[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator -- sums N_TERMS unsigned 8-bit products with
// saturation, then emits the result as two bytes (high byte first).
//   clk   : clock, all state changes on the rising edge
//   rst   : asynchronous active-high reset
//   bus   : product_accumulator_if.slave (clear, product input stream,
//           result byte output stream, overflow/busy status)
// Parameters: N_TERMS (2..255) products per result, ACC_W (9..16) bits.
module product_accumulator
  import pacc_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  product_accumulator_if.slave bus
);

  localparam int              CNT_W       = $clog2(N_TERMS + 1);
  localparam int              RESULT_BITS = 8 * BYTES_PER_RESULT;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(N_TERMS - 1);

  pacc_state_t      state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;

  logic [ACC_W-1:0]       sum;
  logic                   sat;
  logic [RESULT_BITS-1:0] acc_wide;

  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_last;
  logic       in_fire;
  logic       out_fire;

  acc_sat_add #(.ACC_W(ACC_W)) u_add (
    .acc  (acc_reg),
    .prod (bus.in_prod),
    .sum  (sum),
    .sat  (sat)
  );

  // Result is presented zero-extended to the full two-byte width.
  assign acc_wide = RESULT_BITS'(acc_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ACCUM;
      acc_reg      <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_byte      = 8'h00;
    out_last      = 1'b0;

    // Outputs depend only on registered state, so an async reset forces
    // them to idle values without waiting for an edge.
    case (state_reg)
      ACCUM: begin
        in_ready = 1'b1;
      end
      SEND_HI: begin
        out_valid = 1'b1;
        out_byte  = acc_wide[15:8];
      end
      SEND_LO: begin
        out_valid = 1'b1;
        out_byte  = acc_wide[7:0];
        out_last  = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase

    in_fire  = bus.in_valid && in_ready;
    out_fire = out_valid && bus.out_ready;

    if (bus.clear) begin
      // Abort wins over any handshake seen in the same cycle.
      state_next    = ACCUM;
      acc_next      = '0;
      count_next    = '0;
      overflow_next = 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (in_fire) begin
            acc_next      = sum;
            overflow_next = overflow_reg | sat;
            if (count_reg == LAST_CNT) begin
              count_next = '0;
              state_next = SEND_HI;
            end else begin
              count_next = count_reg + 1'b1;
            end
          end
        end
        SEND_HI: begin
          if (out_fire) begin
            state_next = SEND_LO;
          end
        end
        SEND_LO: begin
          if (out_fire) begin
            state_next    = ACCUM;
            acc_next      = '0;
            overflow_next = 1'b0;
          end
        end
        default: begin
          state_next = ACCUM;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_byte  = out_byte;
  assign bus.out_last  = out_last;
  assign bus.overflow  = overflow_reg;
  assign bus.busy      = !((state_reg == ACCUM) && (count_reg == '0));

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator -- directed bench for product_accumulator.
// dut_a uses default parameters and is followed cycle by cycle by a
// behavioural model (list of expected result bytes); dut_b uses
// N_TERMS=8 and is checked against hand-computed values only.
module tb_product_accumulator;
  import pacc_pkg::*;

  localparam int A_N   = 4;
  localparam int A_MAX = (1 << 10) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  product_accumulator_if a_if ();
  product_accumulator_if b_if ();

  product_accumulator dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  product_accumulator #(.N_TERMS(8), .ACC_W(10)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model of dut_a: products taken so far, their saturated sum, the sticky
  // flag, and the bytes still owed downstream.
  int         m_cnt = 0;
  int         m_sum = 0;
  bit         m_ovf = 1'b0;
  logic [7:0] mq[$];
  logic [7:0] got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_sum = 0;
    m_ovf = 1'b0;
    mq.delete();
  endtask

  // Compare and advance the model once per cycle, mid-cycle.
  always @(negedge clk) begin
    bit exp_valid;
    int s;
    if (rst) model_reset();
    exp_valid = (mq.size() != 0);
    check("a_in_ready",  32'(a_if.in_ready),  32'(!exp_valid));
    check("a_out_valid", 32'(a_if.out_valid), 32'(exp_valid));
    check("a_busy",      32'(a_if.busy),      32'(exp_valid || m_cnt != 0));
    check("a_overflow",  32'(a_if.overflow),  32'(m_ovf));
    if (exp_valid) begin
      check("a_out_byte", 32'(a_if.out_byte), 32'(mq[0]));
      check("a_out_last", 32'(a_if.out_last), 32'(mq.size() == 1));
    end else begin
      check("a_out_byte_idle", 32'(a_if.out_byte), 32'h0);
      check("a_out_last_idle", 32'(a_if.out_last), 32'h0);
    end
    if (!rst) begin
      if (a_if.clear) begin
        model_reset();
      end else if (!exp_valid && a_if.in_valid) begin
        s = m_sum + int'(a_if.in_prod);
        if (s > A_MAX) begin
          s = A_MAX;
          m_ovf = 1'b1;
        end
        m_cnt++;
        if (m_cnt == A_N) begin
          mq.push_back(8'((s >> 8) & 255));
          mq.push_back(8'(s & 255));
          m_cnt = 0;
          m_sum = 0;
        end else begin
          m_sum = s;
        end
      end else if (exp_valid && a_if.out_ready) begin
        got.push_back(a_if.out_byte);
        void'(mq.pop_front());
        if (mq.size() == 0) m_ovf = 1'b0;
      end
    end
  end

  // Offer a product to dut_a until it is taken; called just after a posedge.
  task automatic feed(input logic [7:0] p);
    int n;
    bit taken;
    a_if.in_valid = 1'b1;
    a_if.in_prod  = p;
    taken = 1'b0;
    n = 0;
    while (!taken && n < 40) begin
      @(negedge clk);
      taken = a_if.in_ready && !a_if.clear;
      @(posedge clk);
      #1;
      n++;
    end
    a_if.in_valid = 1'b0;
    if (!taken) check("feed_timeout", 32'h0, 32'h1);
  endtask

  task automatic expect_pair(input string name, input logic [7:0] hi, input logic [7:0] lo);
    int k;
    k = 0;
    while (got.size() < 2 && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({name, "_count"}, 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      check({name, "_hi"}, 32'(got[0]), 32'(hi));
      check({name, "_lo"}, 32'(got[1]), 32'(lo));
    end
    $display("result %s: hi=0x%02h lo=0x%02h", name, (got.size() > 0) ? got[0] : 8'h00,
             (got.size() > 1) ? got[1] : 8'h00);
    got.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    a_if.clear = 0; a_if.in_valid = 0; a_if.in_prod = 0; a_if.out_ready = 1;
    b_if.clear = 0; b_if.in_valid = 0; b_if.in_prod = 0; b_if.out_ready = 1;

    // Reset values while rst is held.
    #1;
    check("rst_in_ready",  32'(a_if.in_ready),  32'h1);
    check("rst_out_valid", 32'(a_if.out_valid), 32'h0);
    check("rst_busy",      32'(a_if.busy),      32'h0);
    check("rst_overflow",  32'(a_if.overflow),  32'h0);
    check("rst_out_byte",  32'(a_if.out_byte),  32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();

    // 4 x 255 = 1020 = 0x3FC, just below saturation.
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) feed(8'd255);
    expect_pair("max_no_sat", 8'h03, 8'hFC);

    // 1+2+3+4 = 10 with a stalled sink: high byte must hold.
    a_if.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) feed(8'(i));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(a_if.out_valid), 32'h1);
      check("stall_byte",  32'(a_if.out_byte),  32'h00);
      check("stall_last",  32'(a_if.out_last),  32'h0);
    end
    @(posedge clk);
    #1;
    a_if.out_ready = 1'b1;
    expect_pair("stall", 8'h00, 8'h0A);

    // in_valid held high with 50 during the send: those cycles are ignored.
    a_if.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) feed(8'(i));
    a_if.in_valid = 1'b1;
    a_if.in_prod  = 8'd50;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("send_in_ready", 32'(a_if.in_ready), 32'h0);
    end
    @(posedge clk);
    #1;
    a_if.out_ready = 1'b1;
    expect_pair("held_valid", 8'h00, 8'h0A);
    for (int i = 0; i < 4; i++) feed(8'd50);
    expect_pair("after_held", 8'h00, 8'hC8);

    // Clear after 10,20 discards them and the 30 offered with it.
    feed(8'd10);
    feed(8'd20);
    a_if.clear    = 1'b1;
    a_if.in_valid = 1'b1;
    a_if.in_prod  = 8'd30;
    @(posedge clk);
    #1;
    a_if.clear    = 1'b0;
    a_if.in_valid = 1'b0;
    check("clear_busy", 32'(a_if.busy), 32'h0);
    for (int i = 0; i < 4; i++) feed(8'd1);
    expect_pair("after_clear", 8'h00, 8'h04);

    // Async reset while the low byte is pending.
    a_if.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) feed(8'(i));
    a_if.out_ready = 1'b1;
    k = 0;
    while (!a_if.out_last && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("reach_send_lo", 32'(a_if.out_last), 32'h1);
    a_if.out_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("async_out_valid", 32'(a_if.out_valid), 32'h0);
    check("async_out_last",  32'(a_if.out_last),  32'h0);
    check("async_in_ready",  32'(a_if.in_ready),  32'h1);
    check("async_busy",      32'(a_if.busy),      32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    got.delete();
    a_if.out_ready = 1'b1;
    for (int i = 5; i <= 8; i++) feed(8'(i));
    expect_pair("after_rst", 8'h00, 8'h1A);

    // dut_b: 8 x 200 = 1600 saturates to 0x3FF from the 6th product on.
    @(posedge clk);
    #1;
    b_if.out_ready = 1'b1;
    b_if.in_valid  = 1'b1;
    b_if.in_prod   = 8'd200;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b_in_ready", 32'(b_if.in_ready), 32'h1);
      check("b_ovf_acc",  32'(b_if.overflow), 32'(i >= 6));
      @(posedge clk);
      #1;
    end
    b_if.in_valid = 1'b0;
    @(negedge clk);
    check("b_hi_valid", 32'(b_if.out_valid), 32'h1);
    check("b_hi_byte",  32'(b_if.out_byte),  32'h03);
    check("b_hi_last",  32'(b_if.out_last),  32'h0);
    check("b_hi_ovf",   32'(b_if.overflow),  32'h1);
    $display("result b_sat: hi=0x%02h", b_if.out_byte);
    @(negedge clk);
    check("b_lo_valid", 32'(b_if.out_valid), 32'h1);
    check("b_lo_byte",  32'(b_if.out_byte),  32'hFF);
    check("b_lo_last",  32'(b_if.out_last),  32'h1);
    check("b_lo_ovf",   32'(b_if.overflow),  32'h1);
    $display("result b_sat: lo=0x%02h", b_if.out_byte);
    @(negedge clk);
    check("b_done_valid", 32'(b_if.out_valid), 32'h0);
    check("b_done_ovf",   32'(b_if.overflow),  32'h0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter N_TERMS, default 4: products summed per result; legal range 2..255.
REQ-002 SHALL have parameter ACC_W, default 10: accumulator width; legal range 9..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous abort/restart, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream product valid.
REQ-007 SHALL have port in_prod  input  8  unsigned product from the array multiplier.
REQ-008 SHALL have port in_ready  output  1  block accepts a product this cycle.
REQ-009 SHALL have port out_valid  output  1  out_byte holds a result byte.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the byte.
REQ-011 SHALL have port out_byte  output  8  result byte, high byte first.
REQ-012 SHALL have port out_last  output  1  marks the low (final) byte of a result.
REQ-013 SHALL have port overflow  output  1  sticky flag: current accumulation saturated.
REQ-014 SHALL have port busy  output  1  high when not in ACCUM with count zero.

Function
REQ-015 SHALL implement FSM states ACCUM, SEND_HI, SEND_LO.
REQ-016 In ACCUM, in_ready SHALL be 1; out_valid SHALL be 0.
REQ-017 Input handshake (in_valid and in_ready) SHALL add zero-extended in_prod to acc and increment count.
REQ-018 The add SHALL saturate: if the true sum exceeds 2^ACC_W-1, acc becomes all-ones and overflow sets.
REQ-019 Once set, overflow SHALL stay 1 until the result is fully sent, clear, or rst.
REQ-020 The handshake that brings count to N_TERMS SHALL move the FSM to SEND_HI on the next edge; count resets to 0.
REQ-021 Latency SHALL be one cycle: out_valid rises the cycle after the final input handshake.
REQ-022 In SEND_HI, out_byte SHALL be bits 15:8 of acc zero-extended to 16 bits; out_last 0.
REQ-023 In SEND_LO, out_byte SHALL be bits 7:0 of acc; out_last 1.
REQ-024 In SEND_HI and SEND_LO, in_ready SHALL be 0 and out_valid 1.
REQ-025 out_byte and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 A handshake in SEND_HI SHALL go to SEND_LO; in SEND_LO, it SHALL go to ACCUM with acc=0 and overflow=0.
REQ-027 in_valid SHALL be ignored whenever in_ready=0; no product is lost or double-counted.
REQ-028 clear=1 SHALL take priority over all events: next state ACCUM, acc=0, count=0, overflow=0.
REQ-029 Any input or output handshake in the same cycle as clear SHALL be discarded.
REQ-030 clear in SEND_HI or SEND_LO SHALL drop the pending result; out_valid falls on the next edge.

Reset
REQ-031 While rst=1, the block SHALL hold state ACCUM, acc=0, count=0, overflow=0, in_ready=1, out_valid=0, out_byte=0, out_last=0, busy=0.
REQ-032 Reset mid-accumulation or mid-send SHALL discard all partial state immediately, without waiting for a clock edge.

Structure
REQ-033 The FSM state enum and the constant BYTES_PER_RESULT=2 SHALL live in shared package pacc_pkg.
REQ-034 The saturating adder SHALL be sub-module acc_sat_add; inputs acc, prod; outputs sum, sat.
REQ-035 count width SHALL be clog2(N_TERMS+1).

Verification
REQ-036 Defaults; feed 255,255,255,255 with out_ready=1 -> bytes 0x03 then 0xFC, out_last on 2nd, overflow=0.
REQ-037 Defaults; feed 1,2,3,4 with out_ready low for 3 cycles -> out_byte 0x00 held stable, then 0x00, then 0x0A.
REQ-038 N_TERMS=8, ACC_W=10; feed 200 eight times -> 0x03, 0xFF, overflow=1; flag clears after the low byte.
REQ-039 Defaults; in_valid held high during SEND states -> in_ready=0 and the next sum excludes those cycles.
REQ-040 Defaults; feed 10,20, then pulse clear with in_valid=1 carrying 30; then feed 1,1,1,1 -> result 0x00,0x04.
REQ-041 Defaults; assert rst asynchronously while in SEND_LO -> out_valid=0 before the next edge; next 4-term result is correct.
